// File: rtl/sum_accumulator_pkg.sv
// Shared types and defaults for the frame-based sum accumulator that sits
// behind the 4-bit ripple adder stage.
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_IN_W  = 4;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_COUNT = 16;
  localparam int SAMPLE_W  = DEF_IN_W + 1;

  // The counter must be able to hold the value COUNT itself.
  function automatic int count_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates a frame of COUNT adder results ({cout, sum}) into an ACC_W-bit
// total with a sticky overflow flag, handing the total off via out_valid/out_ack.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int COUNT = DEF_COUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = count_width(COUNT);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W:0]   sample_ext;
  logic [ACC_W:0]   sum_wide;
  logic             accept;
  logic             last_sample;

  assign accept      = in_valid && (state == ACC);
  assign last_sample = (cnt == CNT_W'(COUNT - 1));
  assign sample_ext  = {{(ACC_W - IN_W){1'b0}}, in_cout, in_sum};
  // One extra bit so the carry out of the accumulator becomes the overflow flag.
  assign sum_wide    = {1'b0, acc_out} + sample_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACC;
      ACC:     if (accept && last_sample) state_next = DONE;
      DONE:    if (out_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Total and flag survive into IDLE and are only cleared by the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else if ((state == IDLE) && start) begin
      acc_out <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      acc_out <= sum_wide[ACC_W-1:0];
      ovf     <= ovf | sum_wide[ACC_W];
      cnt     <= cnt + CNT_W'(1);
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed and randomized checks of sum_accumulator against a frame-level
// arithmetic model (running integer total, sample count and phase).
module tb_sum_accumulator;
  import sum_accumulator_pkg::*;

  localparam int IN_W  = DEF_IN_W;
  localparam int ACC_W = DEF_ACC_W;
  localparam int COUNT = DEF_COUNT;
  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_DONE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_sum = '0;
  logic             in_cout = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ack = 1'b0;
  logic             ovf;
  logic             busy;

  int total_checks = 0;
  int bad_checks = 0;
  int m_phase = P_IDLE;
  int m_total = 0;
  int m_count = 0;

  sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready),
    .acc_out(acc_out), .out_valid(out_valid), .out_ack(out_ack),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      bad_checks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The model keeps the exact integer total; the hardware view is that total
  // modulo 2^ACC_W, and overflow is simply "the total ever reached 2^ACC_W".
  task automatic checkOutput(input string tag);
    compare({tag, ":in_ready"}, 32'(in_ready), 32'(m_phase == P_ACC));
    compare({tag, ":out_valid"}, 32'(out_valid), 32'(m_phase == P_DONE));
    compare({tag, ":busy"}, 32'(busy), 32'(m_phase != P_IDLE));
    compare({tag, ":acc_out"}, 32'(acc_out), 32'(m_total % (1 << ACC_W)));
    compare({tag, ":ovf"}, 32'(ovf), 32'(m_total >= (1 << ACC_W)));
  endtask

  task automatic applyStimulus(input string tag, input logic s, input logic v,
                               input logic [IN_W:0] sample, input logic ack);
    start = s;
    in_valid = v;
    {in_cout, in_sum} = sample;
    out_ack = ack;
    @(posedge clk);
    case (m_phase)
      P_IDLE: if (s) begin
        m_phase = P_ACC;
        m_total = 0;
        m_count = 0;
      end
      P_ACC: if (v) begin
        m_total += int'(sample);
        m_count++;
        if (m_count == COUNT) m_phase = P_DONE;
      end
      default: if (ack) m_phase = P_IDLE;
    endcase
    #1;
    checkOutput(tag);
  endtask

  initial begin
    $display("[TB] sum_accumulator bench start");
    #3;
    checkOutput("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("post_reset_idle", 1'b0, 1'b0, 5'd0, 1'b0);

    $display("[TB] back-to-back frame of 5s");
    applyStimulus("sum_start", 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < COUNT; i++) applyStimulus("sum_acc", 1'b0, 1'b1, 5'd5, 1'b0);
    compare("sum_total", 32'(acc_out), 32'h50);
    compare("sum_out_valid", 32'(out_valid), 32'd1);
    applyStimulus("sum_ack", 1'b0, 1'b0, 5'd0, 1'b1);

    $display("[TB] overflow frame");
    applyStimulus("ovf_start", 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < COUNT; i++)
      applyStimulus("ovf_acc", 1'b0, 1'b1, (i % 2 == 0) ? 5'd21 : 5'd22, 1'b0);
    compare("ovf_total", 32'(acc_out), 32'h58);
    compare("ovf_flag", 32'(ovf), 32'd1);
    applyStimulus("ovf_ack", 1'b0, 1'b0, 5'd0, 1'b1);

    $display("[TB] gapped frame and done hold");
    applyStimulus("gap_start", 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4 * COUNT && m_phase == P_ACC; i++)
      applyStimulus("gap_acc", 1'b0, 1'(i % 2), 5'd5, 1'b0);
    compare("gap_total", 32'(acc_out), 32'h50);
    for (int i = 0; i < 5; i++) applyStimulus("done_hold", 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus("done_ack", 1'b0, 1'b1, 5'd9, 1'b1);
    applyStimulus("idle_after_ack", 1'b0, 1'b1, 5'd9, 1'b0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus("mid_start", 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus("mid_acc", 1'b0, 1'b1, 5'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    m_phase = P_IDLE;
    m_total = 0;
    m_count = 0;
    #1;
    checkOutput("mid_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("mid_idle", 1'b0, 1'b1, 5'd3, 1'b0);
    applyStimulus("ones_start", 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < COUNT; i++) applyStimulus("ones_acc", 1'b0, 1'b1, 5'd1, 1'b0);
    compare("ones_total", 32'(acc_out), 32'h10);
    applyStimulus("ones_ack", 1'b0, 1'b0, 5'd0, 1'b1);

    $display("[TB] start rules");
    applyStimulus("rule_start", 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("rule_acc", 1'b0, 1'b1, 5'd2, 1'b0);
    applyStimulus("rule_start_in_acc", 1'b1, 1'b1, 5'd2, 1'b0);
    for (int i = 0; i < 4 * COUNT && m_phase == P_ACC; i++)
      applyStimulus("rule_acc2", 1'b0, 1'b1, 5'd2, 1'b0);
    compare("rule_total", 32'(acc_out), 32'd32);
    applyStimulus("rule_start_with_ack", 1'b1, 1'b0, 5'd0, 1'b1);
    applyStimulus("rule_stay_idle", 1'b0, 1'b1, 5'd7, 1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 4; f++) begin
      applyStimulus("rand_start", 1'b1, 1'b0, 5'd0, 1'b0);
      for (int c = 0; c < 400 && m_phase == P_ACC; c++)
        applyStimulus("rand_acc", 1'b0, 1'($urandom_range(0, 1)),
                      (IN_W + 1)'($urandom_range(0, 31)), 1'b0);
      compare("rand_frame_done", 32'(m_phase), 32'(P_DONE));
      for (int h = 0; h < int'($urandom_range(0, 3)); h++)
        applyStimulus("rand_hold", 1'($urandom_range(0, 1)), 1'b0, 5'd0, 1'b0);
      applyStimulus("rand_ack", 1'b0, 1'b0, 5'd0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
